// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt, iterative shift-add multiply
// and restoring divide behind a start/busy/done handshake.
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WIDTH-1:0] r_op;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic            r_busy;
  logic            r_done;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic            r_zero;
  logic            r_dbz;
  logic            r_illegal;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_hi;
  logic            w_dbz;
  logic            w_illegal;
  logic            w_slt;
  logic [WIDTH:0]  w_mul_sum;
  logic [WIDTH:0]  w_div_shift;
  logic [WIDTH:0]  w_div_diff;
  logic            w_div_neg;
  logic            w_last;

  // Single-cycle result path, also covers divide-by-zero and illegal codes
  assign w_slt = ($signed(a) < $signed(b));

  always_comb begin
    w_res     = '0;
    w_res_hi  = '0;
    w_dbz     = 1'b0;
    w_illegal = 1'b0;
    case (alu_ctrl)
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_ADD: w_res = a + b;
      OP_SUB: w_res = a - b;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_MUL: w_res = '0;
      OP_DIV: begin
        w_res    = '1;
        w_res_hi = a;
        w_dbz    = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // Shift-add step: {r_hi, r_lo} holds partial product / remaining multiplier
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : {(WIDTH+1){1'b0}});

  // Restoring step: remainder stays below divisor, so the top bit is the borrow
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_op};
  assign w_div_neg   = w_div_diff[WIDTH];

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_op        <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_dbz       <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dbz     <= 1'b0;
            r_illegal <= 1'b0;
            if (alu_ctrl == OP_MUL) begin
              r_op    <= a;
              r_lo    <= b;
              r_hi    <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
            end else if (alu_ctrl == OP_DIV && b != '0) begin
              r_op    <= b;
              r_lo    <= a;
              r_hi    <= '0;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_DIV;
            end else begin
              r_result    <= w_res;
              r_result_hi <= w_res_hi;
              r_zero      <= (w_res == '0);
              r_dbz       <= w_dbz;
              r_illegal   <= w_illegal;
              r_done      <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_mul_sum[WIDTH:1];
          r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIN;
        end
        S_DIV: begin
          r_hi  <= w_div_neg ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
          r_lo  <= {r_lo[WIDTH-2:0], ~w_div_neg};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIN;
        end
        S_FIN: begin
          r_result    <= r_lo;
          r_result_hi <= r_hi;
          r_zero      <= (r_lo == '0);
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign zero        = r_zero;
  assign div_by_zero = r_dbz;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: hand-derived vector table, randomized ops against
// an arithmetic reference model, and reset/back-to-back corner sequences.
module tb_multicycle_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         zero;
  logic         div_by_zero;
  logic         illegal;

  int total = 0;
  int bad   = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .zero(zero), .div_by_zero(div_by_zero),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        nm;
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         dbz;
    logic         ill;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] c, input logic [W-1:0] x,
                              input logic [W-1:0] y, input logic [W-1:0] r,
                              input logic [W-1:0] h, input logic d, input logic il);
    vec_t v;
    v.nm = nm; v.ctrl = c; v.a = x; v.b = y; v.res = r; v.hi = h;
    v.z = (r == '0); v.dbz = d; v.ill = il;
    return v;
  endfunction

  // Reference behaviour from plain arithmetic on the operation codes
  function automatic vec_t model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0]  p;
    logic [W-1:0] r;
    logic [W-1:0] h;
    logic         d;
    logic         il;
    r = '0; h = '0; d = 1'b0; il = 1'b0;
    case (c)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0010: r = x + y;
      4'b0110: r = x - y;
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b0101: begin
        p = {32'd0, x} * {32'd0, y};
        r = p[31:0];
        h = p[63:32];
      end
      4'b0100: begin
        if (y == '0) begin
          r = '1; h = x; d = 1'b1;
        end else begin
          r = x / y; h = x % y;
        end
      end
      default: il = 1'b1;
    endcase
    return mk("rand", c, x, y, r, h, d, il);
  endfunction

  // Issue one op, pester the DUT with ignored starts while busy, check completion
  task automatic run_op(input vec_t v);
    int edges;
    int busy_cnt;
    bit multi;
    multi = (v.ctrl == 4'b0101) || (v.ctrl == 4'b0100 && v.b != '0);
    @(negedge clk);
    start = 1'b1; alu_ctrl = v.ctrl; a = v.a; b = v.b;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 4'($urandom); a = $urandom; b = $urandom;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 100) begin
      if (busy) begin
        busy_cnt++;
        start = 1'($urandom_range(0, 1));
        alu_ctrl = 4'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk({v.nm, " latency"}, 64'(edges), multi ? 64'(W + 1) : 64'd0);
    chk({v.nm, " busy_cycles"}, 64'(busy_cnt), multi ? 64'(W + 1) : 64'd0);
    chk({v.nm, " busy_at_done"}, 64'(busy), 64'd0);
    chk({v.nm, " result"}, 64'(result), 64'(v.res));
    chk({v.nm, " result_hi"}, 64'(result_hi), 64'(v.hi));
    chk({v.nm, " zero"}, 64'(zero), 64'(v.z));
    chk({v.nm, " div_by_zero"}, 64'(div_by_zero), 64'(v.dbz));
    chk({v.nm, " illegal"}, 64'(illegal), 64'(v.ill));
    @(posedge clk); #1;
    chk({v.nm, " done_pulse_end"}, 64'(done), 64'd0);
    chk({v.nm, " result_hold"}, 64'(result), 64'(v.res));
  endtask

  initial begin
    int dcount;
    logic [3:0] codes[8];
    vec_t v;

    reset = 1'b1; start = 1'b0; alu_ctrl = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset result_hi", 64'(result_hi), 64'd0);
    chk("reset flags", 64'({zero, div_by_zero, illegal}), 64'd0);

    tbl.push_back(mk("add",      4'b0010, 32'h0000000F, 32'h3, 32'h12, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("sub",      4'b0110, 32'h0000000F, 32'h3, 32'h0C, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("and",      4'b0000, 32'h0000000F, 32'h3, 32'h03, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("or",       4'b0001, 32'h0000000F, 32'h3, 32'h0F, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("sub_eq",   4'b0110, 32'h00000005, 32'h5, 32'h0,  32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1,  32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("slt_swap", 4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h2, 32'h1,  32'h0, 1'b0, 1'b0));
    tbl.push_back(mk("mul",      4'b0101, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h1, 1'b0, 1'b0));
    tbl.push_back(mk("mul_max",  4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0));
    tbl.push_back(mk("div",      4'b0100, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0));
    tbl.push_back(mk("div_zero", 4'b0100, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 1'b1, 1'b0));
    tbl.push_back(mk("div_small",4'b0100, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0));
    tbl.push_back(mk("illegal",  4'b1111, 32'h12345678, 32'h9, 32'h0, 32'h0, 1'b0, 1'b1));
    tbl.push_back(mk("add_after_ill", 4'b0010, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0));
    tbl.push_back(mk("div_max",  4'b0100, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0));

    foreach (tbl[i]) run_op(tbl[i]);

    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1010};
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   c;
      logic [W-1:0] x;
      logic [W-1:0] y;
      c = codes[$urandom_range(0, 7)];
      x = $urandom;
      y = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      run_op(model(c, x, y));
    end

    // Back-to-back single-cycle ops, one accepted per cycle
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0010; a = 32'hF; b = 32'h3;
    @(posedge clk); #1;
    chk("b2b add done", 64'(done), 64'd1);
    chk("b2b add result", 64'(result), 64'h12);
    alu_ctrl = 4'b0110;
    @(posedge clk); #1;
    chk("b2b sub done", 64'(done), 64'd1);
    chk("b2b sub result", 64'(result), 64'h0C);
    alu_ctrl = 4'b0000;
    @(posedge clk); #1;
    chk("b2b and result", 64'(result), 64'h03);
    alu_ctrl = 4'b0001;
    @(posedge clk); #1;
    chk("b2b or result", 64'(result), 64'h0F);
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b idle done", 64'(done), 64'd0);
    chk("b2b hold result", 64'(result), 64'h0F);

    // Reset in the middle of a multiply aborts it without a done pulse
    run_op(mk("pre_abort", 4'b0010, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0));
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0101; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("abort busy_before", 64'(busy), 64'd1);
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort result_hi", 64'(result_hi), 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("abort no_late_done", 64'(dcount), 64'd0);

    // Reset and start together: start is dropped
    run_op(mk("pre_rs", 4'b0010, 32'd1, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b1; start = 1'b1; alu_ctrl = 4'b0010; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rs done", 64'(done), 64'd0);
    chk("rs result", 64'(result), 64'd0);
    @(posedge clk); #1;
    chk("rs no_done_later", 64'(done), 64'd0);
    chk("rs result_later", 64'(result), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
